fp16_rom_sqrt_pipe: RTL and testbench

//  Multi-lane, 3-stage pipelined FP16 square root with valid/ready handshake.

---
 rtl/fp16_sqrt_pkg.sv | 23 ++
 rtl/fp16_sqrt_lane.sv | 58 +++++
 rtl/fp16_rom_sqrt_pipe.sv | 188 ++++++++++++++++++
 tb/tb_fp16_rom_sqrt_pipe.sv | 323 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fp16_sqrt_pkg.sv
// Shared constants, the square-root seed table and the operand class type
// for the pipelined FP16 ROM square root.
package fp16_sqrt_pkg;

    localparam logic [15:0] FP16_QNAN = 16'h7E00;
    localparam logic [15:0] FP16_PINF = 16'h7C00;

    // Indexed by {~e[0], x1}: odd exponents use the low half, even the high half.
    localparam logic [10:0] SQRT_ROM [16] = '{
        11'h785, 11'h6AE, 11'h5F6, 11'h557, 11'h4CC, 11'h450, 11'h3E2, 11'h37E,
        11'h323, 11'h285, 11'h1FE, 11'h18A, 11'h124, 11'h0CA, 11'h07A, 11'h031
    };

    typedef enum logic [2:0] {
        ZERO = 3'd0,
        SUB  = 3'd1,
        NORM = 3'd2,
        INF  = 3'd3,
        QNAN = 3'd4,
        SNAN = 3'd5
    } fp16_class_e;

endpackage

// File: rtl/fp16_sqrt_lane.sv
// Combinational per-lane front end: operand classification, seed lookup,
// multiplier operand formation and result exponent.
module fp16_sqrt_lane
    import fp16_sqrt_pkg::*;
(
    input  logic [15:0]  op_i,
    output fp16_class_e  cls_o,
    output logic         sign_o,
    output logic [10:0]  c_o,
    output logic [11:0]  x_o,
    output logic [4:0]   eo_o
);

    logic [4:0]        e_s;
    logic [2:0]        x1_s;
    logic [6:0]        x2_s;
    logic [2:0]        hi_s;
    logic [4:0]        ebias_s;
    logic signed [4:0] ehalf_s;

    assign e_s    = op_i[14:10];
    assign x1_s   = op_i[9:7];
    assign x2_s   = op_i[6:0];
    assign sign_o = op_i[15];

    // Classify the operand from its exponent and mantissa fields.
    always_comb begin
        cls_o = NORM;
        if (e_s == 5'd31) begin
            if (op_i[9:0] == 10'd0) begin
                cls_o = INF;
            end else if (op_i[9]) begin
                cls_o = QNAN;
            end else begin
                cls_o = SNAN;
            end
        end else if (e_s == 5'd0) begin
            if (op_i[9:0] == 10'd0) begin
                cls_o = ZERO;
            end else begin
                cls_o = SUB;
            end
        end else begin
            cls_o = NORM;
        end
    end

    assign c_o  = SQRT_ROM[{~e_s[0], x1_s}];
    assign hi_s = {1'b0, x2_s[6:5]} + 3'd1;
    assign x_o  = e_s[0] ? {1'b1, x1_s, x2_s[6], ~x2_s[6], x2_s[5:0]}
                         : {1'b1, x1_s, hi_s, x2_s[4:0]};

    // Halve the unbiased exponent with floor rounding, wrapping in 5 bits.
    assign ebias_s = e_s - 5'd15;
    assign ehalf_s = $signed(ebias_s) >>> 1;
    assign eo_o    = $unsigned(ehalf_s) + 5'd15;

endmodule

// File: rtl/fp16_rom_sqrt_pipe.sv
// Multi-lane 3-stage FP16 square root (decode/ROM, multiply, normalise/special)
// under one shared valid/ready chain with flush.
module fp16_rom_sqrt_pipe
    import fp16_sqrt_pkg::*;
#(
    parameter int LANES = 1,
    parameter int TAG_W = 4
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 flush_i,
    input  logic                 in_valid_i,
    output logic                 in_ready_o,
    input  logic [16*LANES-1:0]  operands_i,
    input  logic [TAG_W-1:0]     tag_i,
    output logic                 out_valid_o,
    input  logic                 out_ready_i,
    output logic [16*LANES-1:0]  result_o,
    output logic [TAG_W-1:0]     tag_o,
    output logic [2*LANES-1:0]   status_o
);

    fp16_class_e [LANES-1:0]        lane_cls_s;
    logic [LANES-1:0]               lane_sign_s;
    logic [LANES-1:0][10:0]         lane_c_s;
    logic [LANES-1:0][11:0]         lane_x_s;
    logic [LANES-1:0][4:0]          lane_eo_s;

    logic vld1_q, vld2_q, vld3_q;
    logic vld1_d, vld2_d, vld3_d;
    logic rdy1_s, rdy2_s, rdy3_s;
    logic ld1_s, ld2_s, ld3_s;

    fp16_class_e [LANES-1:0]        s1_cls_q;
    logic [LANES-1:0]               s1_sign_q;
    logic [LANES-1:0][10:0]         s1_c_q;
    logic [LANES-1:0][11:0]         s1_x_q;
    logic [LANES-1:0][4:0]          s1_eo_q;
    logic [TAG_W-1:0]               s1_tag_q;

    fp16_class_e [LANES-1:0]        s2_cls_q;
    logic [LANES-1:0]               s2_sign_q;
    logic [LANES-1:0][4:0]          s2_eo_q;
    logic [LANES-1:0][23:0]         s2_p_q;
    logic [LANES-1:0][23:0]         s2_p_d;
    logic [TAG_W-1:0]               s2_tag_q;

    logic [LANES-1:0][9:0]          mant_s;
    logic [16*LANES-1:0]            result_q, result_d;
    logic [2*LANES-1:0]             status_q, status_d;
    logic [TAG_W-1:0]               tag_q;

    for (genvar k = 0; k < LANES; k++) begin : g_lane
        fp16_sqrt_lane u_lane (
            .op_i   (operands_i[16*k +: 16]),
            .cls_o  (lane_cls_s[k]),
            .sign_o (lane_sign_s[k]),
            .c_o    (lane_c_s[k]),
            .x_o    (lane_x_s[k]),
            .eo_o   (lane_eo_s[k])
        );
    end

    assign rdy3_s     = !vld3_q || out_ready_i;
    assign rdy2_s     = !vld2_q || rdy3_s;
    assign rdy1_s     = !vld1_q || rdy2_s;
    assign in_ready_o = rdy1_s;

    assign ld1_s = rdy1_s && in_valid_i;
    assign ld2_s = rdy2_s && vld1_q;
    assign ld3_s = rdy3_s && vld2_q;

    // Stage valid chain: advance where the next stage has room, clear on flush.
    always_comb begin
        vld1_d = vld1_q;
        vld2_d = vld2_q;
        vld3_d = vld3_q;
        if (flush_i) begin
            vld1_d = 1'b0;
            vld2_d = 1'b0;
            vld3_d = 1'b0;
        end else begin
            if (rdy1_s) vld1_d = in_valid_i; else vld1_d = vld1_q;
            if (rdy2_s) vld2_d = vld1_q;     else vld2_d = vld2_q;
            if (rdy3_s) vld3_d = vld2_q;     else vld3_d = vld3_q;
        end
    end

    // Multiply stage and final normalise/special-case selection per lane.
    always_comb begin
        s2_p_d   = '0;
        mant_s   = '0;
        result_d = '0;
        status_d = '0;
        for (int k = 0; k < LANES; k++) begin
            s2_p_d[k] = 24'({1'b1, s1_c_q[k]}) * 24'(s1_x_q[k]);
            mant_s[k] = s2_p_q[k][23] ? s2_p_q[k][22:13] : s2_p_q[k][21:12];
            result_d[16*k +: 16] = FP16_QNAN;
            status_d[2*k +: 2]   = 2'b00;
            case (s2_cls_q[k])
                ZERO: result_d[16*k +: 16] = {s2_sign_q[k], 15'd0};
                SUB: begin
                    result_d[16*k +: 16] = {s2_sign_q[k], 15'd0};
                    status_d[2*k +: 2]   = 2'b01;
                end
                INF: begin
                    if (s2_sign_q[k]) begin
                        result_d[16*k +: 16] = FP16_QNAN;
                        status_d[2*k +: 2]   = 2'b10;
                    end else begin
                        result_d[16*k +: 16] = FP16_PINF;
                        status_d[2*k +: 2]   = 2'b00;
                    end
                end
                QNAN: result_d[16*k +: 16] = FP16_QNAN;
                SNAN: begin
                    result_d[16*k +: 16] = FP16_QNAN;
                    status_d[2*k +: 2]   = 2'b10;
                end
                NORM: begin
                    if (s2_sign_q[k]) begin
                        result_d[16*k +: 16] = FP16_QNAN;
                        status_d[2*k +: 2]   = 2'b10;
                    end else begin
                        result_d[16*k +: 16] = {1'b0, s2_eo_q[k], mant_s[k]};
                        status_d[2*k +: 2]   = 2'b00;
                    end
                end
                default: result_d[16*k +: 16] = FP16_QNAN;
            endcase
        end
    end

    // Pipeline registers; a stage only loads when it can accept, so stalls hold data.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            vld1_q    <= 1'b0;
            vld2_q    <= 1'b0;
            vld3_q    <= 1'b0;
            s1_sign_q <= '0;
            s1_c_q    <= '0;
            s1_x_q    <= '0;
            s1_eo_q   <= '0;
            s1_tag_q  <= '0;
            s2_sign_q <= '0;
            s2_eo_q   <= '0;
            s2_p_q    <= '0;
            s2_tag_q  <= '0;
            result_q  <= '0;
            status_q  <= '0;
            tag_q     <= '0;
            for (int k = 0; k < LANES; k++) begin
                s1_cls_q[k] <= ZERO;
                s2_cls_q[k] <= ZERO;
            end
        end else begin
            vld1_q <= vld1_d;
            vld2_q <= vld2_d;
            vld3_q <= vld3_d;
            if (ld1_s) begin
                s1_cls_q  <= lane_cls_s;
                s1_sign_q <= lane_sign_s;
                s1_c_q    <= lane_c_s;
                s1_x_q    <= lane_x_s;
                s1_eo_q   <= lane_eo_s;
                s1_tag_q  <= tag_i;
            end
            if (ld2_s) begin
                s2_cls_q  <= s1_cls_q;
                s2_sign_q <= s1_sign_q;
                s2_eo_q   <= s1_eo_q;
                s2_p_q    <= s2_p_d;
                s2_tag_q  <= s1_tag_q;
            end
            if (ld3_s) begin
                result_q <= result_d;
                status_q <= status_d;
                tag_q    <= s2_tag_q;
            end
        end
    end

    assign out_valid_o = vld3_q;
    assign result_o    = result_q;
    assign status_o    = status_q;
    assign tag_o       = tag_q;

endmodule

// File: tb/tb_fp16_rom_sqrt_pipe.sv
// Scoreboard bench for fp16_rom_sqrt_pipe with four lanes: accepted beats are
// modelled arithmetically and queued, a monitor pops and compares each output.
module tb_fp16_rom_sqrt_pipe;

    localparam int LANES = 4;
    localparam int TAG_W = 4;

    typedef struct packed {
        logic [63:0] res;
        logic [7:0]  sts;
        logic [3:0]  tag;
    } exp_t;

    logic        clk;
    logic        rst_i;
    logic        flush_i;
    logic        in_valid_i;
    logic        in_ready_o;
    logic [63:0] operands_i;
    logic [3:0]  tag_i;
    logic        out_valid_o;
    logic        out_ready_i;
    logic [63:0] result_o;
    logic [3:0]  tag_o;
    logic [7:0]  status_o;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   rom_tab[16] = '{'h785, 'h6AE, 'h5F6, 'h557, 'h4CC, 'h450, 'h3E2, 'h37E,
                          'h323, 'h285, 'h1FE, 'h18A, 'h124, 'h0CA, 'h07A, 'h031};
    bit   in_t3 = 1'b0;
    int   t3_cnt = 0, t3_first = 0, t3_last = 0;
    bit   t5_watch = 1'b0;
    int   t5_leak = 0;

    fp16_rom_sqrt_pipe #(.LANES(LANES), .TAG_W(TAG_W)) dut (
        .clk_i       (clk),
        .rst_i       (rst_i),
        .flush_i     (flush_i),
        .in_valid_i  (in_valid_i),
        .in_ready_o  (in_ready_o),
        .operands_i  (operands_i),
        .tag_i       (tag_i),
        .out_valid_o (out_valid_o),
        .out_ready_i (out_ready_i),
        .result_o    (result_o),
        .tag_o       (tag_o),
        .status_o    (status_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    // Reference: sqrt rules written as integer arithmetic. Returns {nv, ftz, result}.
    function automatic logic [17:0] ref_sqrt(input logic [15:0] op);
        int e, mant, x1, x2, c, xv, p, d, eo, m;
        logic [4:0] eo5;
        logic [9:0] m10;
        e    = int'(op[14:10]);
        mant = int'(op[9:0]);
        if (e == 31) begin
            if (mant == 0) return op[15] ? {2'b10, 16'h7E00} : {2'b00, 16'h7C00};
            return {~op[9], 1'b0, 16'h7E00};
        end
        if (e == 0) begin
            if (mant == 0) return {2'b00, op};
            return {2'b01, op[15], 15'd0};
        end
        if (op[15]) return {2'b10, 16'h7E00};
        x1 = mant / 128;
        x2 = mant % 128;
        c  = rom_tab[((e % 2) == 1 ? 0 : 8) + x1];
        if ((e % 2) == 1) xv = 2048 + x1 * 256 + ((x2 >= 64) ? 128 : 64) + x2 % 64;
        else              xv = 2048 + x1 * 256 + (((x2 / 32) + 1) % 8) * 32 + x2 % 32;
        p  = (2048 + c) * xv;
        m  = (p >= 8388608) ? (p / 8192) % 1024 : (p / 4096) % 1024;
        d  = e - 15;
        eo = ((d + 16) / 2) - 8 + 15;
        eo5 = 5'(eo);
        m10 = 10'(m);
        return {2'b00, 1'b0, eo5, m10};
    endfunction

    function automatic exp_t make_exp(input logic [63:0] ops, input logic [3:0] tg);
        exp_t        x;
        logic [17:0] r;
        x.tag = tg;
        x.res = '0;
        x.sts = '0;
        for (int k = 0; k < LANES; k++) begin
            r = ref_sqrt(ops[16*k +: 16]);
            x.res[16*k +: 16] = r[15:0];
            x.sts[2*k +: 2]   = r[17:16];
        end
        return x;
    endfunction

    function automatic logic [15:0] rand_op();
        logic [15:0] sp [8];
        logic [15:0] v;
        sp = '{16'h0000, 16'h8000, 16'h7C00, 16'hFC00, 16'h7E01, 16'h7C01, 16'h0001, 16'h83FF};
        case ($urandom_range(0, 3))
            0, 1: begin
                v = 16'($urandom);
                v[15] = 1'b0;
                v[14:10] = 5'($urandom_range(1, 30));
            end
            2: v = 16'($urandom);
            default: v = sp[$urandom_range(0, 7)];
        endcase
        return v;
    endfunction

    function automatic logic [63:0] rand_ops();
        return {rand_op(), rand_op(), rand_op(), rand_op()};
    endfunction

    // Acceptance tracker: push the modelled response for every accepted beat.
    always @(negedge clk) begin
        if (rst_i || flush_i) exp_q.delete();
        else if (in_valid_i && in_ready_o) exp_q.push_back(make_exp(operands_i, tag_i));
    end

    // Monitor: pop and compare on every output handshake.
    always @(negedge clk) begin
        exp_t e;
        if (!rst_i && out_valid_o && t5_watch && tag_o >= 4'd8 && tag_o <= 4'd11) t5_leak++;
        if (!rst_i && out_valid_o && out_ready_i && !flush_i) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_output actual_tag=%h required=none", tag_o);
            end else begin
                e = exp_q.pop_front();
                chk("result", result_o, e.res);
                chk("tag", 64'(tag_o), 64'(e.tag));
                chk("status", 64'(status_o), 64'(e.sts));
            end
            if (in_t3) begin
                if (t3_cnt == 0) t3_first = cyc;
                t3_last = cyc;
                t3_cnt++;
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [63:0] ops, input logic [3:0] tg, output int tries);
        bit ok;
        ok = 1'b0;
        tries = 0;
        in_valid_i = 1'b1;
        operands_i = ops;
        tag_i = tg;
        while (!ok && tries < 50) begin
            @(negedge clk);
            tries++;
            if (in_ready_o) ok = 1'b1;
            @(posedge clk);
            #1;
        end
        in_valid_i = 1'b0;
        if (!ok) chk("send_timeout", 64'd0, 64'd1);
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 100) begin
            step();
            n++;
        end
        chk("drain", 64'(exp_q.size()), 64'd0);
    endtask

    // Single beat with lane 0 checked against a literal answer and latency 3.
    task automatic one_beat(input logic [15:0] op, input logic [15:0] r, input logic [1:0] s);
        int tries, n;
        send({rand_op(), rand_op(), rand_op(), op}, 4'($urandom), tries);
        n = 1;
        @(negedge clk);
        while (!out_valid_o && n < 10) begin
            @(negedge clk);
            n++;
        end
        chk("latency", 64'(n), 64'd3);
        chk("lane0_result", 64'(result_o[15:0]), 64'(r));
        chk("lane0_status", 64'(status_o[1:0]), 64'(s));
        step();
    endtask

    initial begin
        int          tries, n;
        logic [63:0] hold_r;
        logic [3:0]  hold_t;

        rst_i = 1'b1; flush_i = 1'b0; in_valid_i = 1'b0;
        operands_i = '0; tag_i = '0; out_ready_i = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst_i = 1'b0;
        @(negedge clk);
        chk("rst_out_valid", 64'(out_valid_o), 64'd0);
        chk("rst_result", result_o, 64'd0);
        chk("rst_tag", 64'(tag_o), 64'd0);
        chk("rst_status", 64'(status_o), 64'd0);
        chk("rst_in_ready", 64'(in_ready_o), 64'd1);
        step();

        // T1 and T2: literal results on lane 0
        one_beat(16'h3C00, 16'h3C00, 2'b00);
        one_beat(16'h4400, 16'h4000, 2'b00);
        one_beat(16'h0000, 16'h0000, 2'b00);
        one_beat(16'h8000, 16'h8000, 2'b00);
        one_beat(16'h7C00, 16'h7C00, 2'b00);
        one_beat(16'hC400, 16'h7E00, 2'b10);
        one_beat(16'h7C01, 16'h7E00, 2'b10);
        one_beat(16'h0001, 16'h0000, 2'b01);
        one_beat(16'h8001, 16'h8000, 2'b01);
        drain();

        // T3: 64 back-to-back random beats
        in_t3 = 1'b1;
        for (int i = 0; i < 64; i++) begin
            send(rand_ops(), 4'(i), tries);
            chk("t3_accept_first_try", 64'(tries), 64'd1);
        end
        drain();
        in_t3 = 1'b0;
        chk("t3_count", 64'(t3_cnt), 64'd64);
        chk("t3_no_gaps", 64'(t3_last - t3_first), 64'd63);

        // T4: backpressure with a full pipe
        out_ready_i = 1'b0;
        send(rand_ops(), 4'd1, tries);
        send(rand_ops(), 4'd2, tries);
        send(rand_ops(), 4'd3, tries);
        in_valid_i = 1'b1;
        operands_i = rand_ops();
        tag_i = 4'd4;
        @(negedge clk);
        hold_r = result_o;
        hold_t = tag_o;
        chk("t4_head_tag", 64'(tag_o), 64'd1);
        for (int i = 0; i < 5; i++) begin
            chk("t4_in_ready", 64'(in_ready_o), 64'd0);
            chk("t4_out_valid", 64'(out_valid_o), 64'd1);
            chk("t4_result_stable", result_o, hold_r);
            chk("t4_tag_stable", 64'(tag_o), 64'(hold_t));
            @(negedge clk);
        end
        @(posedge clk);
        #1 out_ready_i = 1'b1;
        send(operands_i, 4'd4, tries);
        drain();

        // T5: flush with three beats in flight and a fourth offered
        t5_leak = 0;
        send(rand_ops(), 4'd8, tries);
        send(rand_ops(), 4'd9, tries);
        send(rand_ops(), 4'd10, tries);
        out_ready_i = 1'b0;
        flush_i = 1'b1;
        in_valid_i = 1'b1;
        operands_i = rand_ops();
        tag_i = 4'd11;
        step();
        flush_i = 1'b0;
        in_valid_i = 1'b0;
        out_ready_i = 1'b1;
        t5_watch = 1'b1;
        @(negedge clk);
        chk("t5_out_valid_after_flush", 64'(out_valid_o), 64'd0);
        step();
        repeat (8) step();
        t5_watch = 1'b0;
        chk("t5_flushed_tags_seen", 64'(t5_leak), 64'd0);
        one_beat(16'h3C00, 16'h3C00, 2'b00);
        drain();

        // T6: asynchronous reset between edges with a beat at the output
        send(rand_ops(), 4'd5, tries);
        send(rand_ops(), 4'd6, tries);
        send(rand_ops(), 4'd7, tries);
        #1 chk("t6_out_valid_before_reset", 64'(out_valid_o), 64'd1);
        #1 rst_i = 1'b1;
        #1 chk("t6_out_valid_in_reset", 64'(out_valid_o), 64'd0);
        chk("t6_result_in_reset", result_o, 64'd0);
        @(posedge clk);
        @(posedge clk);
        #3 rst_i = 1'b0;
        step();
        chk("t6_queue_cleared", 64'(exp_q.size()), 64'd0);
        one_beat(16'h4400, 16'h4000, 2'b00);
        drain();

        n = exp_q.size();
        chk("final_empty", 64'(n), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

endmodule
